ksa_gen: RTL and testbench
==========================

KSA_GEN -- requirements
Module: ksa_gen

Interface
REQ-001 SHALL have parameter KEY_BYTES, default 3; key length in bytes, legal range 1..32.
REQ-002 SHALL have parameter ADDR_W, default 8; state array size N = 2^ADDR_W; data width equals ADDR_W.
REQ-003 SHALL have parameter DO_INIT, default 1; 1 = run the identity pass S[i]=i before shuffling, 0 = shuffle pre-loaded memory only.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  start request; sampled only when rdy=1.
REQ-007 rdy  output  1  high when idle and able to accept en.
REQ-008 done  output  1  one-cycle pulse when a run completes.
REQ-009 key  input  8*KEY_BYTES  key; byte 0 = key[8*KEY_BYTES-1 -: 8]; latched at start.
REQ-010 addr  output  ADDR_W  memory address.
REQ-011 rddata  input  ADDR_W  memory read data; valid the cycle after addr is presented.
REQ-012 wrdata  output  ADDR_W  memory write data.
REQ-013 wren  output  1  memory write enable; one write per cycle maximum.

Function
REQ-014 Start: rising edge with rdy=1 and en=1 latches key, clears i and j to 0, drops rdy the next cycle.
REQ-015 States: IDLE, INIT, RD_I, RD_J, WR_I, WR_J, DONE; encoding is an enum in the package.
REQ-016 IDLE: rdy=1, wren=0; en=1 goes to INIT if DO_INIT=1, else RD_I.
REQ-017 INIT: one cycle per i, addr=i, wrdata=i, wren=1; after i=N-1, clear i and go to RD_I.
REQ-018 RD_I: addr=i, wren=0.
REQ-019 RD_J: si <= rddata; jn = j + rddata + kb, mod 2^ADDR_W; kb = low ADDR_W bits of key byte (i mod KEY_BYTES); addr=jn, j <= jn, wren=0.
REQ-020 WR_I: addr=i, wrdata=rddata (S[j]), wren=1.
REQ-021 WR_J: addr=j, wrdata=si, wren=1; if i=N-1 go DONE, else i <= i+1 and go RD_I.
REQ-022 Shuffle timing: exactly 4 cycles per i, 4N cycles total.
REQ-023 i=j case: WR_I then WR_J both write addr i; the final value equals si.
REQ-024 DONE: done=1, rdy=0, wren=0 for one cycle, then IDLE.
REQ-025 Latency: rdy is low for exactly (DO_INIT ? N : 0) + 4N + 1 cycles after the start edge.
REQ-026 en while busy: ignored; the key input may change freely while busy.
REQ-027 en held high: a new run starts on the first IDLE edge after DONE.
REQ-028 i wraps only via the DONE transition; j wraps modulo N silently.

Reset
REQ-029 rst=1 forces IDLE immediately, without waiting for clk, including mid-run.
REQ-030 Reset values: rdy=1, done=0, wren=0, addr=0, wrdata=0, i=0, j=0, si=0, latched key=0.
REQ-031 A run aborted by reset is not resumed; memory contents are then undefined.

Structure
REQ-032 Package ksa_pkg SHALL hold the state enum typedef and the default constants KEY_BYTES_DEF=3 and ADDR_W_DEF=8.
REQ-033 RTL SHALL be a single module with no sub-modules; key byte selection is inline.
REQ-034 The bench SHALL use a 1-cycle-read-latency RAM model, write-then-read visible on the next cycle.

Verification
REQ-035 Defaults, key=24'h00033C, one en pulse -> INIT writes 0..255.
  - First shuffle writes: (addr0,0), (addr0,0), then (addr1,4), (addr4,1).
  - Final memory matches the software RC4 KSA model.
REQ-036 Cycle count, defaults -> rdy low for exactly 1281 cycles; done pulses once, in the last of them.
REQ-037 en re-asserted at cycle 100 of a run -> no effect; en held high through DONE -> second run starts on the next edge with an identical result.
REQ-038 rst asserted mid-shuffle (cycle 600), asynchronous to clk -> wren=0 and rdy=1 before the next edge; after release, a new run completes correctly.
REQ-039 KEY_BYTES=1, ADDR_W=4, DO_INIT=0, memory preloaded with 15-i, key=8'h2A -> first write occurs in the 3rd cycle after start; rdy low for 65 cycles; memory matches the model with 4-bit arithmetic.
REQ-040 Key tied so j==i on the first iteration (key byte0=0, S[0]=0) -> WR_I and WR_J both target addr 0 with value 0; no corruption.

Source files
------------

// File: rtl/ksa_pkg.sv
// Shared definitions for the RC4 key-scheduling engine: default sizing and
// the controller state encoding.
package ksa_pkg;

  localparam int KEY_BYTES_DEF = 3;
  localparam int ADDR_W_DEF    = 8;

  // One state per memory cycle of the schedule. INIT is skipped when the
  // engine is configured to shuffle a pre-loaded table.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_RD_I = 3'd2,
    S_RD_J = 3'd3,
    S_WR_I = 3'd4,
    S_WR_J = 3'd5,
    S_DONE = 3'd6
  } ksa_state_t;

endpackage

// File: rtl/ksa_gen.sv
// RC4 key-scheduling engine driving an external single-port RAM with a
// one-cycle read latency. Every i of the shuffle takes four cycles:
// read S[i], read S[j], write S[j] to i, then write S[i] to j.
// addr/wrdata are decoded from registered state, except in RD_J and WR_I
// where they must follow rddata in the same cycle to keep that cadence.
module ksa_gen
  import ksa_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DO_INIT   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  output logic                   done,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [ADDR_W-1:0]      addr,
  input  logic [ADDR_W-1:0]      rddata,
  output logic [ADDR_W-1:0]      wrdata,
  output logic                   wren
);

  // Width of the key-byte index; kept at least one bit for single-byte keys.
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  ksa_state_t             state_reg;
  logic [ADDR_W-1:0]      i_reg;
  logic [ADDR_W-1:0]      j_reg;
  logic [ADDR_W-1:0]      si_reg;
  logic [KIDX_W-1:0]      kidx_reg;
  logic [8*KEY_BYTES-1:0] key_reg;
  logic                   rdy_reg;
  logic                   done_reg;
  logic                   wren_reg;

  logic                   i_last;
  logic                   kidx_last;
  logic [7:0]             kbyte;
  logic [ADDR_W-1:0]      kb;
  logic [ADDR_W-1:0]      jn;
  logic [ADDR_W-1:0]      addr_next;
  logic [ADDR_W-1:0]      wrdata_next;

  assign i_last    = &i_reg;
  assign kidx_last = (kidx_reg == KIDX_W'(KEY_BYTES - 1));

  // Select key byte (i mod KEY_BYTES); kidx_reg tracks that residue so no
  // divider is needed. Byte 0 sits in the most significant position.
  always_comb begin
    kbyte = 8'h00;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx_reg == KIDX_W'(b)) begin
        kbyte = key_reg[8*(KEY_BYTES-1-b) +: 8];
      end
    end
  end

  assign kb = ADDR_W'(kbyte);
  assign jn = j_reg + rddata + kb;

  // Memory address and write data for the current state.
  always_comb begin
    addr_next   = '0;
    wrdata_next = '0;
    case (state_reg)
      S_INIT: begin
        addr_next   = i_reg;
        wrdata_next = i_reg;
      end
      S_RD_I: addr_next = i_reg;
      S_RD_J: addr_next = jn;
      S_WR_I: begin
        addr_next   = i_reg;
        wrdata_next = rddata;
      end
      S_WR_J: begin
        addr_next   = j_reg;
        wrdata_next = si_reg;
      end
      default: begin
        addr_next   = '0;
        wrdata_next = '0;
      end
    endcase
  end

  assign addr   = addr_next;
  assign wrdata = wrdata_next;
  assign rdy    = rdy_reg;
  assign done   = done_reg;
  assign wren   = wren_reg;

  // Controller: sequences the schedule and registers rdy/done/wren for the
  // state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      si_reg    <= '0;
      kidx_reg  <= '0;
      key_reg   <= '0;
      rdy_reg   <= 1'b1;
      done_reg  <= 1'b0;
      wren_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (en) begin
            key_reg  <= key;
            i_reg    <= '0;
            j_reg    <= '0;
            kidx_reg <= '0;
            rdy_reg  <= 1'b0;
            if (DO_INIT != 0) begin
              state_reg <= S_INIT;
              wren_reg  <= 1'b1;
            end else begin
              state_reg <= S_RD_I;
              wren_reg  <= 1'b0;
            end
          end
        end
        S_INIT: begin
          if (i_last) begin
            i_reg     <= '0;
            state_reg <= S_RD_I;
            wren_reg  <= 1'b0;
          end else begin
            i_reg <= i_reg + ADDR_W'(1);
          end
        end
        S_RD_I: begin
          state_reg <= S_RD_J;
        end
        S_RD_J: begin
          si_reg    <= rddata;
          j_reg     <= jn;
          state_reg <= S_WR_I;
          wren_reg  <= 1'b1;
        end
        S_WR_I: begin
          state_reg <= S_WR_J;
        end
        S_WR_J: begin
          wren_reg <= 1'b0;
          if (i_last) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end else begin
            i_reg     <= i_reg + ADDR_W'(1);
            kidx_reg  <= kidx_last ? '0 : kidx_reg + KIDX_W'(1);
            state_reg <= S_RD_I;
          end
        end
        S_DONE: begin
          i_reg     <= '0;
          done_reg  <= 1'b0;
          rdy_reg   <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          rdy_reg   <= 1'b1;
          done_reg  <= 1'b0;
          wren_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_gen.sv
// Bench for ksa_gen: default-sized instance plus a small pre-loaded 4-bit
// instance, each with a 1-cycle-latency RAM model and a write scoreboard
// fed by a software RC4 KSA model.
module tb_ksa_gen;

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr8_t;
  typedef struct packed { logic [3:0] a; logic [3:0] d; } wr4_t;
  typedef struct { logic [23:0] key; int exp_cycles; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en1, rdy1, done1, wren1;
  logic [23:0] key1;
  logic [7:0]  addr1, wrdata1, rd1;
  logic        en2, rdy2, done2, wren2;
  logic [7:0]  key2;
  logic [3:0]  addr2, wrdata2, rd2;
  logic        pre_we2;
  logic [3:0]  pre_a2, pre_d2;

  ksa_gen u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .rdy(rdy1), .done(done1), .key(key1),
    .addr(addr1), .rddata(rd1), .wrdata(wrdata1), .wren(wren1)
  );

  ksa_gen #(.KEY_BYTES(1), .ADDR_W(4), .DO_INIT(0)) u_dut2 (
    .clk(clk), .rst(rst), .en(en2), .rdy(rdy2), .done(done2), .key(key2),
    .addr(addr2), .rddata(rd2), .wrdata(wrdata2), .wren(wren2)
  );

  logic [7:0] mem1 [256];
  logic [3:0] mem2 [16];

  always @(posedge clk) begin
    if (wren1) mem1[addr1] <= wrdata1;
    rd1 <= mem1[addr1];
  end

  always @(posedge clk) begin
    if (pre_we2) mem2[pre_a2] <= pre_d2;
    else if (wren2) mem2[addr2] <= wrdata2;
    rd2 <= mem2[addr2];
  end

  int n_chk = 0;
  int n_fail = 0;
  wr8_t q1[$];
  wr4_t q2[$];
  wr8_t e1;
  wr4_t e2;
  int wbad1, wbad2, wn1;
  logic [7:0] wlog_a [4];
  logic [7:0] wlog_d [4];
  logic [7:0] exp1 [256];
  logic [3:0] exp2 [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Scoreboard for the default instance; logs the first four shuffle writes.
  always @(negedge clk) begin
    if (!rst && wren1) begin
      if (wn1 >= 256 && wn1 < 260) begin
        wlog_a[wn1-256] = addr1;
        wlog_d[wn1-256] = wrdata1;
      end
      wn1++;
      if (q1.size() == 0) wbad1++;
      else begin
        e1 = q1.pop_front();
        if (addr1 !== e1.a || wrdata1 !== e1.d) wbad1++;
      end
    end
  end

  // Scoreboard for the 4-bit instance.
  always @(negedge clk) begin
    if (!rst && wren2) begin
      if (q2.size() == 0) wbad2++;
      else begin
        e2 = q2.pop_front();
        if (addr2 !== e2.a || wrdata2 !== e2.d) wbad2++;
      end
    end
  end

  // Software RC4 KSA (N=256, 3-byte key) producing the expected write stream.
  task automatic model1(input logic [23:0] k);
    logic [7:0] s [256];
    logic [7:0] j, t, kb;
    wr8_t w;
    for (int i = 0; i < 256; i++) begin
      s[i] = 8'(i);
      w.a = 8'(i);
      w.d = 8'(i);
      q1.push_back(w);
    end
    j = 8'h00;
    for (int i = 0; i < 256; i++) begin
      kb = k[23-8*(i%3) -: 8];
      j = j + s[i] + kb;
      w.a = 8'(i); w.d = s[j]; q1.push_back(w);
      w.a = j;     w.d = s[i]; q1.push_back(w);
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int i = 0; i < 256; i++) exp1[i] = s[i];
  endtask

  // Same KSA with 4-bit arithmetic over a table pre-loaded with 15-i.
  task automatic model2(input logic [7:0] k);
    logic [3:0] s [16];
    logic [3:0] j, t, kb;
    wr4_t w;
    for (int i = 0; i < 16; i++) s[i] = 4'(15 - i);
    kb = k[3:0];
    j = 4'h0;
    for (int i = 0; i < 16; i++) begin
      j = j + s[i] + kb;
      w.a = 4'(i); w.d = s[j]; q2.push_back(w);
      w.a = j;     w.d = s[i]; q2.push_back(w);
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int i = 0; i < 16; i++) exp2[i] = s[i];
  endtask

  task automatic start1(input bit hold);
    model1(key1);
    if (hold) model1(key1);
    wbad1 = 0;
    wn1 = 0;
    @(negedge clk);
    en1 = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy1_drop", rdy1, 0);
    if (!hold) en1 = 1'b0;
  endtask

  // Counts busy cycles until rdy returns; optionally pokes en mid-run.
  task automatic wait1(input int poke, output int cyc, output int done_at, output int ndone);
    cyc = 0; done_at = -1; ndone = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      if (rdy1) break;
      cyc++;
      if (done1) begin ndone++; done_at = cyc; end
      if (poke > 0 && cyc == poke) en1 = 1'b1;
      if (poke > 0 && cyc == poke + 1) en1 = 1'b0;
    end
  endtask

  task automatic check_run1(input string tag, input int cyc, input int done_at,
                            input int ndone, input int exp_left);
    int bad;
    bad = 0;
    chk({tag, "_cycles"}, cyc, 1281);
    chk({tag, "_done_at"}, done_at, 1281);
    chk({tag, "_done_cnt"}, ndone, 1);
    chk({tag, "_wr_seq"}, wbad1, 0);
    chk({tag, "_q_left"}, q1.size(), exp_left);
    for (int i = 0; i < 256; i++) if (mem1[i] !== exp1[i]) bad++;
    chk({tag, "_mem"}, bad, 0);
    $display("run %s: cycles=%0d done_at=%0d bad_writes=%0d bad_mem=%0d", tag, cyc, done_at, wbad1, bad);
  endtask

  vec_t vecs [5];
  int cyc, da, nd, first2, bad2;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en1 = 1'b0; en2 = 1'b0; key1 = '0; key2 = '0;
    pre_we2 = 1'b0; pre_a2 = '0; pre_d2 = '0;
    wbad1 = 0; wbad2 = 0; wn1 = 0;
    vecs[0] = '{24'h00033C, 1281};
    vecs[1] = '{24'h000000, 1281};
    vecs[2] = '{24'hFFFFFF, 1281};
    vecs[3] = '{24'h010203, 1281};
    vecs[4] = '{24'hA55AC3, 1281};

    #12;
    chk("rst_rdy1", rdy1, 1);
    chk("rst_done1", done1, 0);
    chk("rst_wren1", wren1, 0);
    chk("rst_addr1", addr1, 0);
    chk("rst_wrdata1", wrdata1, 0);
    chk("rst_rdy2", rdy2, 1);
    chk("rst_wren2", wren2, 0);
    chk("rst_addr2", addr2, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven runs; the key input is scrambled while busy.
    for (int v = 0; v < 5; v++) begin
      key1 = vecs[v].key;
      start1(1'b0);
      key1 = 24'($urandom);
      wait1(0, cyc, da, nd);
      chk($sformatf("vec%0d_latency", v), cyc, vecs[v].exp_cycles);
      check_run1($sformatf("vec%0d", v), cyc, da, nd, 0);
      if (v == 0) begin
        chk("first_wr0_addr", wlog_a[0], 0);
        chk("first_wr0_data", wlog_d[0], 0);
        chk("first_wr1_addr", wlog_a[1], 0);
        chk("first_wr1_data", wlog_d[1], 0);
        chk("first_wr2_addr", wlog_a[2], 1);
        chk("first_wr2_data", wlog_d[2], 4);
        chk("first_wr3_addr", wlog_a[3], 4);
        chk("first_wr3_data", wlog_d[3], 1);
      end
    end

    // en pulsed while busy must be ignored.
    key1 = 24'h00033C;
    start1(1'b0);
    wait1(100, cyc, da, nd);
    check_run1("busy_en", cyc, da, nd, 0);

    // en held through DONE restarts on the first IDLE edge.
    key1 = 24'h00033C;
    start1(1'b1);
    wait1(0, cyc, da, nd);
    check_run1("hold_a", cyc, da, nd, 768);
    @(posedge clk);
    #1;
    chk("hold_restart", rdy1, 0);
    en1 = 1'b0;
    wait1(0, cyc, da, nd);
    check_run1("hold_b", cyc, da, nd, 0);

    // Asynchronous reset mid-shuffle, then a clean run.
    key1 = 24'h123456;
    start1(1'b0);
    repeat (600) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wren", wren1, 0);
    chk("arst_rdy", rdy1, 1);
    chk("arst_done", done1, 0);
    chk("arst_addr", addr1, 0);
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    key1 = 24'h00033C;
    start1(1'b0);
    wait1(0, cyc, da, nd);
    check_run1("after_rst", cyc, da, nd, 0);

    // 4-bit instance, no INIT pass, table pre-loaded with 15-i.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pre_we2 = 1'b1;
      pre_a2 = 4'(i);
      pre_d2 = 4'(15 - i);
    end
    @(negedge clk);
    pre_we2 = 1'b0;
    key2 = 8'h2A;
    model2(key2);
    wbad2 = 0;
    en2 = 1'b1;
    @(posedge clk);
    #1;
    en2 = 1'b0;
    chk("small_rdy_drop", rdy2, 0);
    cyc = 0; da = -1; nd = 0; first2 = -1;
    while (cyc < 500) begin
      @(negedge clk);
      if (rdy2) break;
      cyc++;
      if (wren2 && first2 < 0) first2 = cyc;
      if (done2) begin nd++; da = cyc; end
    end
    bad2 = 0;
    for (int i = 0; i < 16; i++) if (mem2[i] !== exp2[i]) bad2++;
    chk("small_cycles", cyc, 65);
    chk("small_first_wr", first2, 3);
    chk("small_done_at", da, 65);
    chk("small_done_cnt", nd, 1);
    chk("small_wr_seq", wbad2, 0);
    chk("small_q_left", q2.size(), 0);
    chk("small_mem", bad2, 0);
    $display("run small: cycles=%0d first_wr=%0d bad_writes=%0d bad_mem=%0d", cyc, first2, wbad2, bad2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
